ascon_ctrl_fsm: RTL and testbench
=================================

// Module: ascon_ctrl_fsm
// PURPOSE
//  Sequencer for the ASCON-128 encryption datapath: init (p12), one AD block (p6),
//  N plaintext blocks (p6 each except last), finalisation (p12), tag.
//  Drives the round counter (enable/init_a/init_b) and the permutation's xor/mux
//  controls. Accepts data blocks via a valid/ready handshake. Sits beside the counter, above the permutation.
// PARAMETERS
//  NB_BLK_W    3   width of plaintext block-count input (max 2**NB_BLK_W-1 blocks)
//  ROUND_LAST  11  last round index of every permutation (from package)
// PORTS
//  clock_i          in   1         system clock, single domain
//  reset_i          in   1         synchronous, active-high reset
//  start_i          in   1         start one encryption (sampled in IDLE only)
//  nb_blk_i         in   NB_BLK_W  plaintext block count, sampled with start_i
//  data_valid_i     in   1         AD/PT block present on datapath input
//  round_i          in   4         round counter value (counter_o of round counter)
//  data_ready_o     out  1         controller waiting for a block
//  enable_cpt_o     out  1         round counter enable
//  init_a_o         out  1         counter load 0 (p12 start)
//  init_b_o         out  1         counter load 6 (p6 start)
//  init_state_o     out  1         permutation input mux selects IV||K||N
//  xor_data_begin_o out  1         xor data block into state before round
//  xor_key_begin_o  out  1         xor 0||K||0 before round (finalisation)
//  xor_key_end_o    out  1         xor 0..0||K after round
//  xor_lsb_end_o    out  1         xor domain-separation bit after round
//  cipher_valid_o   out  1         ciphertext block valid (1-cycle pulse)
//  tag_valid_o      out  1         tag valid, encryption done (1-cycle pulse)
//  busy_o           out  1         high in every state except IDLE
// BEHAVIOUR
//  - Reset: state IDLE, block index 0, all outputs 0 from the next edge; mid-operation
//    reset aborts immediately. Counter reset is separate and not driven here.
//  - Moore outputs, except data_ready_o/handshake-start (Mealy on data_valid_i in WAIT states).
//  - IDLE: start_i=1 -> INIT_LD, latch nb_blk_i (0 treated as 1); start_i ignored elsewhere.
//  - INIT_LD (1 cyc): enable_cpt_o=1, init_a_o=1 -> P12_INIT.
//  - P12_INIT: enable_cpt_o=1; round_i==0: init_state_o=1; round_i==11: xor_key_end_o=1 -> AD_WAIT.
//  - AD_WAIT: data_ready_o=1; on data_valid_i: enable_cpt_o=1, init_b_o=1 same cycle -> P6_AD.
//  - P6_AD: enable_cpt_o=1; round 6: xor_data_begin_o=1; round 11: xor_lsb_end_o=1 -> PT_WAIT.
//  - PT_WAIT: data_ready_o=1; on data_valid_i: if blk_idx < nb-1: init_b_o, enable_cpt_o -> P6_PT;
//    else init_a_o, enable_cpt_o -> P12_FIN.
//  - P6_PT: enable_cpt_o=1; round 6: xor_data_begin_o=1, cipher_valid_o=1; round 11:
//    blk_idx++ -> PT_WAIT.
//  - P12_FIN: enable_cpt_o=1; round 0: xor_data_begin_o, xor_key_begin_o, cipher_valid_o=1;
//    round 11: xor_key_end_o=1 -> TAG.
//  - TAG (1 cyc): tag_valid_o=1 -> IDLE (start_i in TAG ignored; accepted from IDLE).
//  - Exit from every RUN state only on round_i==ROUND_LAST; round_i 12..15 in RUN -> IDLE (fault).
//  - Latency: init 13 cyc from start_i; each p6 block 7 cyc incl. load; final 13 cyc + 1 TAG.
//  - data_valid_i outside WAIT states ignored; enable_cpt_o=0 in IDLE/WAIT/TAG (counter holds).
// STRUCTURE
//  - ascon_pkg: typedef enum state_t {IDLE,INIT_LD,P12_INIT,AD_WAIT,P6_AD,PT_WAIT,P6_PT,
//    P12_FIN,TAG}; constants ROUND_LAST=11, ROUND_P6=6, ROUND_P12=0.
//  - Single module: state register + next-state/output logic + NB_BLK_W block index;
//    no sub-module. Bench instantiates it with the round counter in the loop.
// TESTING
//  - reset_i=1 mid P12_INIT (round 5) -> next cycle IDLE, all outputs 0, busy_o=0.
//  - start_i, nb_blk_i=1 -> init_a_o @t+1, xor_key_end_o @t+13, data_ready_o @t+14.
//  - nb_blk_i=3, valid each WAIT -> 2 P6_PT + P12_FIN, cipher_valid_o x3, tag_valid_o x1.
//  - data_valid_i held low 10 cyc in PT_WAIT -> enable_cpt_o=0, round_i stable, then resumes.
//  - nb_blk_i=0 -> behaves as 1: AD block then directly P12_FIN, one cipher_valid_o.
//  - start_i pulsed during P6_AD -> ignored, block count unchanged; start_i in TAG -> ignored.

Source files
------------

// File: rtl/ascon_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// ascon_ctrl_fsm_pkg
// Shared types and constants for the ASCON-128 encryption sequencer.
//   state_t     : controller states, IDLE through TAG
//   ROUND_LAST  : last round index of every permutation (p12 and p6)
//   ROUND_P6    : round counter load value at the start of a p6
//   ROUND_P12   : round counter load value at the start of a p12
//   round_fault : true for counter values a running permutation never reaches
// ---------------------------------------------------------------------------
package ascon_ctrl_fsm_pkg;

    localparam logic [3:0] ROUND_LAST = 4'd11;
    localparam logic [3:0] ROUND_P6   = 4'd6;
    localparam logic [3:0] ROUND_P12  = 4'd0;

    typedef enum logic [3:0] {
        IDLE,
        INIT_LD,
        P12_INIT,
        AD_WAIT,
        P6_AD,
        PT_WAIT,
        P6_PT,
        P12_FIN,
        TAG
    } state_t;

    // Rounds 12..15 cannot occur while a permutation is running; seeing one
    // means the counter and the controller have lost step with each other.
    function automatic logic round_fault(input logic [3:0] round);
        return round > ROUND_LAST;
    endfunction

endpackage

// File: rtl/ascon_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// ascon_ctrl_fsm_if
// Control bundle between the ASCON sequencer and its surroundings
// (round counter, permutation datapath, block source).
//   start_i, nb_blk_i     : request one encryption of nb_blk_i plaintext blocks
//   data_valid_i          : AD/PT block present on the datapath input
//   round_i               : current round counter value
//   data_ready_o          : controller is waiting for a block
//   enable_cpt_o, init_a_o, init_b_o : round counter step / load 0 / load 6
//   init_state_o, xor_*   : permutation input mux and xor controls
//   cipher_valid_o, tag_valid_o : one-cycle result strobes
//   busy_o                : an encryption is in progress
// modport master : side driving requests and the round value (bench/top level)
// modport slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface ascon_ctrl_fsm_if #(
    parameter int NB_BLK_W = 3
);

    logic                start_i;
    logic [NB_BLK_W-1:0] nb_blk_i;
    logic                data_valid_i;
    logic [3:0]          round_i;
    logic                data_ready_o;
    logic                enable_cpt_o;
    logic                init_a_o;
    logic                init_b_o;
    logic                init_state_o;
    logic                xor_data_begin_o;
    logic                xor_key_begin_o;
    logic                xor_key_end_o;
    logic                xor_lsb_end_o;
    logic                cipher_valid_o;
    logic                tag_valid_o;
    logic                busy_o;

    modport master (
        output start_i, nb_blk_i, data_valid_i, round_i,
        input  data_ready_o, enable_cpt_o, init_a_o, init_b_o, init_state_o,
               xor_data_begin_o, xor_key_begin_o, xor_key_end_o, xor_lsb_end_o,
               cipher_valid_o, tag_valid_o, busy_o
    );

    modport slave (
        input  start_i, nb_blk_i, data_valid_i, round_i,
        output data_ready_o, enable_cpt_o, init_a_o, init_b_o, init_state_o,
               xor_data_begin_o, xor_key_begin_o, xor_key_end_o, xor_lsb_end_o,
               cipher_valid_o, tag_valid_o, busy_o
    );

endinterface

// File: rtl/ascon_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// ascon_ctrl_fsm
// Sequencer for the ASCON-128 encryption datapath:
//   init p12 -> one AD block p6 -> (N-1) plaintext p6 -> final block + p12 -> tag.
// Drives the round counter and the permutation's xor/mux controls, and takes
// data blocks through a valid/ready handshake.
// Ports:
//   clock_i : system clock
//   reset_i : synchronous, active-high reset (aborts any encryption)
//   ctrl    : ascon_ctrl_fsm_if.slave control bundle (see interface header)
// ---------------------------------------------------------------------------
module ascon_ctrl_fsm
    import ascon_ctrl_fsm_pkg::*;
#(
    parameter int NB_BLK_W = 3
) (
    input logic             clock_i,
    input logic             reset_i,
    ascon_ctrl_fsm_if.slave ctrl
);

    localparam logic [NB_BLK_W-1:0] BLK_ZERO = '0;
    localparam logic [NB_BLK_W-1:0] BLK_ONE  = {{(NB_BLK_W-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_next;
    logic [NB_BLK_W-1:0] blk_idx;
    logic [NB_BLK_W-1:0] nb_last;

    logic data_ready;
    logic enable_cpt;
    logic init_a;
    logic init_b;
    logic init_state;
    logic xor_data_begin;
    logic xor_key_begin;
    logic xor_key_end;
    logic xor_lsb_end;
    logic cipher_valid;
    logic tag_valid;

    // nb_last holds the index of the final plaintext block. A request for
    // zero blocks is treated as one block, so both map to index 0.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state   <= IDLE;
            blk_idx <= BLK_ZERO;
            nb_last <= BLK_ZERO;
        end else begin
            state <= state_next;
            if (state == IDLE && ctrl.start_i) begin
                blk_idx <= BLK_ZERO;
                nb_last <= (ctrl.nb_blk_i == BLK_ZERO) ? BLK_ZERO : ctrl.nb_blk_i - BLK_ONE;
            end else if (state == P6_PT && ctrl.round_i == ROUND_LAST) begin
                blk_idx <= blk_idx + BLK_ONE;
            end
        end
    end

    // Outputs are decoded from state and round, except in the two WAIT
    // states where the counter load is issued in the same cycle the block
    // is accepted, so the permutation starts without a bubble.
    always_comb begin
        state_next     = state;
        data_ready     = 1'b0;
        enable_cpt     = 1'b0;
        init_a         = 1'b0;
        init_b         = 1'b0;
        init_state     = 1'b0;
        xor_data_begin = 1'b0;
        xor_key_begin  = 1'b0;
        xor_key_end    = 1'b0;
        xor_lsb_end    = 1'b0;
        cipher_valid   = 1'b0;
        tag_valid      = 1'b0;

        case (state)
            IDLE: begin
                if (ctrl.start_i) begin
                    state_next = INIT_LD;
                end
            end
            INIT_LD: begin
                enable_cpt = 1'b1;
                init_a     = 1'b1;
                state_next = P12_INIT;
            end
            P12_INIT: begin
                enable_cpt = 1'b1;
                if (ctrl.round_i == ROUND_P12) begin
                    init_state = 1'b1;
                end
                if (ctrl.round_i == ROUND_LAST) begin
                    xor_key_end = 1'b1;
                    state_next  = AD_WAIT;
                end else if (round_fault(ctrl.round_i)) begin
                    state_next = IDLE;
                end
            end
            AD_WAIT: begin
                data_ready = 1'b1;
                if (ctrl.data_valid_i) begin
                    enable_cpt = 1'b1;
                    init_b     = 1'b1;
                    state_next = P6_AD;
                end
            end
            P6_AD: begin
                enable_cpt = 1'b1;
                if (ctrl.round_i == ROUND_P6) begin
                    xor_data_begin = 1'b1;
                end
                if (ctrl.round_i == ROUND_LAST) begin
                    xor_lsb_end = 1'b1;
                    state_next  = PT_WAIT;
                end else if (round_fault(ctrl.round_i)) begin
                    state_next = IDLE;
                end
            end
            PT_WAIT: begin
                data_ready = 1'b1;
                if (ctrl.data_valid_i) begin
                    enable_cpt = 1'b1;
                    if (blk_idx < nb_last) begin
                        init_b     = 1'b1;
                        state_next = P6_PT;
                    end else begin
                        init_a     = 1'b1;
                        state_next = P12_FIN;
                    end
                end
            end
            P6_PT: begin
                enable_cpt = 1'b1;
                if (ctrl.round_i == ROUND_P6) begin
                    xor_data_begin = 1'b1;
                    cipher_valid   = 1'b1;
                end
                if (ctrl.round_i == ROUND_LAST) begin
                    state_next = PT_WAIT;
                end else if (round_fault(ctrl.round_i)) begin
                    state_next = IDLE;
                end
            end
            P12_FIN: begin
                enable_cpt = 1'b1;
                if (ctrl.round_i == ROUND_P12) begin
                    xor_data_begin = 1'b1;
                    xor_key_begin  = 1'b1;
                    cipher_valid   = 1'b1;
                end
                if (ctrl.round_i == ROUND_LAST) begin
                    xor_key_end = 1'b1;
                    state_next  = TAG;
                end else if (round_fault(ctrl.round_i)) begin
                    state_next = IDLE;
                end
            end
            TAG: begin
                tag_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ctrl.data_ready_o     = data_ready;
    assign ctrl.enable_cpt_o     = enable_cpt;
    assign ctrl.init_a_o         = init_a;
    assign ctrl.init_b_o         = init_b;
    assign ctrl.init_state_o     = init_state;
    assign ctrl.xor_data_begin_o = xor_data_begin;
    assign ctrl.xor_key_begin_o  = xor_key_begin;
    assign ctrl.xor_key_end_o    = xor_key_end;
    assign ctrl.xor_lsb_end_o    = xor_lsb_end;
    assign ctrl.cipher_valid_o   = cipher_valid;
    assign ctrl.tag_valid_o      = tag_valid;
    assign ctrl.busy_o           = (state != IDLE);

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_ascon_ctrl_fsm
// Bench for the ASCON sequencer with a simple round counter in the loop.
// Each encryption is expanded into a per-cycle table of inputs and expected
// outputs, built from the phase lengths of the algorithm (p12 = 12 rounds
// from 0, p6 = 6 rounds from 6, waits of chosen length), then applied and
// compared cycle by cycle. Inputs that should be ignored are randomized.
// ---------------------------------------------------------------------------
module tb_ascon_ctrl_fsm;

    localparam int NB_BLK_W = 3;

    localparam logic [11:0] B_RDY = 12'h800;
    localparam logic [11:0] B_EN  = 12'h400;
    localparam logic [11:0] B_IA  = 12'h200;
    localparam logic [11:0] B_IB  = 12'h100;
    localparam logic [11:0] B_IS  = 12'h080;
    localparam logic [11:0] B_XDB = 12'h040;
    localparam logic [11:0] B_XKB = 12'h020;
    localparam logic [11:0] B_XKE = 12'h010;
    localparam logic [11:0] B_XLE = 12'h008;
    localparam logic [11:0] B_CV  = 12'h004;
    localparam logic [11:0] B_TV  = 12'h002;
    localparam logic [11:0] B_BSY = 12'h001;

    typedef struct {
        logic                start;
        logic [NB_BLK_W-1:0] nb;
        logic                valid;
        logic [11:0]         exp;
        logic [3:0]          expRound;
        bit                  roundCare;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cnt;
    logic       roundForce = 1'b0;
    logic [3:0] roundForceVal = 4'd0;
    int         checkCount = 0;
    int         passCount = 0;
    vec_t       sched[$];

    always #5 clock = ~clock;

    ascon_ctrl_fsm_if #(.NB_BLK_W(NB_BLK_W)) bus();

    ascon_ctrl_fsm #(.NB_BLK_W(NB_BLK_W)) dut (
        .clock_i(clock),
        .reset_i(reset),
        .ctrl   (bus)
    );

    // Round counter neighbour: load 0 on init_a, load 6 on init_b, else count.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (bus.enable_cpt_o) begin
            if (bus.init_a_o) begin
                cnt <= 4'd0;
            end else if (bus.init_b_o) begin
                cnt <= 4'd6;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign bus.round_i = roundForce ? roundForceVal : cnt;

    function automatic vec_t mkVec(input logic s, input logic [NB_BLK_W-1:0] n, input logic va,
                                   input logic [11:0] e, input logic [3:0] r, input bit c);
        vec_t v;
        v.start = s; v.nb = n; v.valid = va;
        v.exp = e; v.expRound = r; v.roundCare = c;
        return v;
    endfunction

    // Cycle whose start/nb/valid are don't-care inputs for the controller.
    function automatic vec_t noiseVec(input logic [11:0] e, input logic [3:0] r, input bit c);
        return mkVec(1'($urandom), NB_BLK_W'($urandom), 1'($urandom), e, r, c);
    endfunction

    task automatic pushRounds(input int first, input int last,
                              input logic [11:0] firstBits, input logic [11:0] lastBits);
        for (int r = first; r <= last; r++) begin
            logic [11:0] e;
            e = B_EN | B_BSY;
            if (r == first) e = e | firstBits;
            if (r == last)  e = e | lastBits;
            sched.push_back(noiseVec(e, 4'(r), 1'b1));
        end
    endtask

    // A wait always follows a permutation whose last round stepped the
    // counter to 12, and the counter must hold there while idle.
    task automatic pushWait(input int delay, input logic [11:0] acceptBits);
        for (int d = 0; d < delay; d++) begin
            sched.push_back(mkVec(1'($urandom), NB_BLK_W'($urandom), 1'b0,
                                  B_RDY | B_BSY, 4'd12, 1'b1));
        end
        sched.push_back(mkVec(1'($urandom), NB_BLK_W'($urandom), 1'b1,
                              B_RDY | B_EN | B_BSY | acceptBits, 4'd12, 1'b1));
    endtask

    // delayMode < 0 picks a random 0..4 cycle wait before each block.
    task automatic buildSchedule(input int nbIn, input int delayMode);
        int nbEff;
        nbEff = (nbIn == 0) ? 1 : nbIn;
        sched.delete();
        sched.push_back(mkVec(1'b1, NB_BLK_W'(nbIn), 1'($urandom), 12'h000, 4'd0, 1'b0));
        sched.push_back(noiseVec(B_EN | B_IA | B_BSY, 4'd0, 1'b0));
        pushRounds(0, 11, B_IS, B_XKE);
        pushWait((delayMode < 0) ? int'($urandom_range(0, 4)) : delayMode, B_IB);
        pushRounds(6, 11, B_XDB, B_XLE);
        for (int k = 0; k < nbEff - 1; k++) begin
            pushWait((delayMode < 0) ? int'($urandom_range(0, 4)) : delayMode, B_IB);
            pushRounds(6, 11, B_XDB | B_CV, 12'h000);
        end
        pushWait((delayMode < 0) ? int'($urandom_range(0, 4)) : delayMode, B_IA);
        pushRounds(0, 11, B_XDB | B_XKB | B_CV, B_XKE);
        sched.push_back(noiseVec(B_TV | B_BSY, 4'd12, 1'b1));
        sched.push_back(mkVec(1'b0, NB_BLK_W'($urandom), 1'($urandom), 12'h000, 4'd12, 1'b1));
        sched.push_back(mkVec(1'b0, NB_BLK_W'($urandom), 1'($urandom), 12'h000, 4'd12, 1'b1));
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.start_i      = v.start;
        bus.nb_blk_i     = v.nb;
        bus.data_valid_i = v.valid;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        logic [11:0] act;
        act = {bus.data_ready_o, bus.enable_cpt_o, bus.init_a_o, bus.init_b_o,
               bus.init_state_o, bus.xor_data_begin_o, bus.xor_key_begin_o,
               bus.xor_key_end_o, bus.xor_lsb_end_o, bus.cipher_valid_o,
               bus.tag_valid_o, bus.busy_o};
        checkCount++;
        if (act !== v.exp || (v.roundCare && bus.round_i !== v.expRound)) begin
            $display("[TB] FAIL %s: got outputs=%b round=%0d, expected outputs=%b round=%0d (round checked=%0d)",
                     name, act, bus.round_i, v.exp, v.expRound, v.roundCare);
        end else begin
            passCount++;
        end
    endtask

    // One table entry per clock: drive after the edge, compare on the falling edge.
    task automatic stepCheck(input vec_t v, input string name);
        applyStimulus(v);
        @(negedge clock);
        checkOutput(v, name);
        @(posedge clock);
        #1;
    endtask

    task automatic runSchedule(input string name, input int upto);
        int n;
        n = (upto < 0 || upto > sched.size()) ? sched.size() : upto;
        for (int i = 0; i < n; i++) begin
            stepCheck(sched[i], $sformatf("%s[%0d]", name, i));
        end
    endtask

    initial begin
        vec_t v;
        bus.start_i      = 1'b0;
        bus.nb_blk_i     = '0;
        bus.data_valid_i = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Reset held: start must be ignored and every output stays low.
        for (int i = 0; i < 2; i++) begin
            stepCheck(mkVec(1'b1, 3'd2, 1'b1, 12'h000, 4'd0, 1'b1), "reset_hold");
        end
        reset = 1'b0;
        stepCheck(mkVec(1'b0, 3'd0, 1'b1, 12'h000, 4'd0, 1'b1), "after_reset");

        buildSchedule(1, 0);   runSchedule("nb1", -1);
        buildSchedule(3, 0);   runSchedule("nb3", -1);
        buildSchedule(2, 10);  runSchedule("stall10", -1);
        buildSchedule(0, -1);  runSchedule("nb0", -1);
        buildSchedule(7, 1);   runSchedule("nb7", -1);
        for (int k = 0; k < 6; k++) begin
            buildSchedule(int'($urandom_range(0, 7)), -1);
            runSchedule($sformatf("rand%0d", k), -1);
        end

        // Reset arriving at round 5 of the init permutation aborts at once.
        buildSchedule(1, 0);
        runSchedule("abort", 7);
        v = sched[7];
        reset = 1'b1;
        stepCheck(v, "abort_r5");
        reset = 1'b0;
        stepCheck(mkVec(1'b0, 3'd1, 1'b1, 12'h000, 4'd0, 1'b0), "abort_idle0");
        stepCheck(mkVec(1'b0, 3'd1, 1'b1, 12'h000, 4'd0, 1'b0), "abort_idle1");

        // Out-of-range round during P6_AD forces a return to IDLE.
        buildSchedule(1, 0);
        runSchedule("fault", 16);
        roundForce    = 1'b1;
        roundForceVal = 4'd13;
        stepCheck(mkVec(1'b0, 3'd1, 1'b0, B_EN | B_BSY, 4'd13, 1'b1), "fault_r13");
        roundForce = 1'b0;
        stepCheck(mkVec(1'b0, 3'd1, 1'b1, 12'h000, 4'd0, 1'b0), "fault_idle0");
        stepCheck(mkVec(1'b0, 3'd1, 1'b1, 12'h000, 4'd0, 1'b0), "fault_idle1");

        buildSchedule(2, -1);  runSchedule("recover", -1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
